bldc_encoder_check_sequencer: RTL and testbench

Windowed encoder-plausibility sequencer for one BLDC motor channel. It sits between the free-running encoder and hall counters and the motor fault logic. On every window strobe it snapshots both counters, forms per-window magnitudes, and judges each window with an encoder-stall rule. A latched `fault` is raised only after a configurable run of consecutive bad windows.

---
 rtl/bldc_pkg.sv | 37 +++
 rtl/bldc_encoder_check_sequencer_if.sv | 31 +++
 rtl/bldc_window_judge.sv | 35 +++
 rtl/bldc_encoder_check_sequencer.sv | 175 +++++++++++++++++
 tb/tb_bldc_encoder_check_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bldc_pkg.sv
// Shared types, default parameters and the saturating magnitude helper
// for the BLDC encoder plausibility sequencer.
package bldc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    localparam int BLDC_ENC_W        = 15;
    localparam int BLDC_HALL_W       = 8;
    localparam int BLDC_ENC_MIN      = 2;
    localparam int BLDC_HALL_MAX     = 1;
    localparam int BLDC_STRIKE_LIMIT = 3;
    localparam int BLDC_STRIKE_W     = 4;

    // |delta| of a width-bit two's-complement value held in the low bits of
    // a 32-bit word; the most-negative value saturates to the largest positive.
    function automatic logic [31:0] abs_sat(input logic [31:0] delta, input int width);
        logic [31:0] mask;
        logic [31:0] min_neg;
        logic [31:0] d;
        mask    = (32'd1 << width) - 32'd1;
        min_neg = 32'd1 << (width - 1);
        d       = delta & mask;
        if (d == min_neg) begin
            return min_neg - 32'd1;
        end
        if ((d & min_neg) != 32'd0) begin
            return (~d + 32'd1) & mask;
        end
        return d;
    endfunction

endpackage

// File: rtl/bldc_encoder_check_sequencer_if.sv
// Counter inputs, control strobes and window results of one motor channel.
interface bldc_encoder_check_sequencer_if #(
    parameter int ENC_W    = bldc_pkg::BLDC_ENC_W,
    parameter int HALL_W   = bldc_pkg::BLDC_HALL_W,
    parameter int STRIKE_W = bldc_pkg::BLDC_STRIKE_W
) ();

    logic              enable;
    logic              tick;
    logic              fault_clear;
    logic [ENC_W-1:0]  enc_count;
    logic [HALL_W-1:0] hall_count;

    logic                win_valid;
    logic [ENC_W-1:0]    win_enc;
    logic [HALL_W-1:0]   win_hall;
    logic                win_bad;
    logic [STRIKE_W-1:0] strike_count;
    logic                fault;

    modport master (
        output enable, tick, fault_clear, enc_count, hall_count,
        input  win_valid, win_enc, win_hall, win_bad, strike_count, fault
    );

    modport slave (
        input  enable, tick, fault_clear, enc_count, hall_count,
        output win_valid, win_enc, win_hall, win_bad, strike_count, fault
    );

endinterface

// File: rtl/bldc_window_judge.sv
// Combinational evaluation of one window: wrapped deltas against the
// baselines, saturated magnitudes and the encoder-stall rule.
module bldc_window_judge
    import bldc_pkg::*;
#(
    parameter int ENC_W    = BLDC_ENC_W,
    parameter int HALL_W   = BLDC_HALL_W,
    parameter int ENC_MIN  = BLDC_ENC_MIN,
    parameter int HALL_MAX = BLDC_HALL_MAX
) (
    input  logic [ENC_W-1:0]  i_enc_count,
    input  logic [ENC_W-1:0]  i_enc_base,
    input  logic [HALL_W-1:0] i_hall_count,
    input  logic [HALL_W-1:0] i_hall_base,
    output logic [ENC_W-1:0]  o_enc_mag,
    output logic [HALL_W-1:0] o_hall_mag,
    output logic              o_bad
);

    localparam logic [ENC_W-1:0]  ENC_MIN_V  = ENC_W'(ENC_MIN);
    localparam logic [HALL_W-1:0] HALL_MAX_V = HALL_W'(HALL_MAX);

    logic [ENC_W-1:0]  w_enc_delta;
    logic [HALL_W-1:0] w_hall_delta;

    // Subtraction at the counter width gives the modular wrap for free.
    assign w_enc_delta  = i_enc_count - i_enc_base;
    assign w_hall_delta = i_hall_count - i_hall_base;

    assign o_enc_mag  = ENC_W'(abs_sat(32'(w_enc_delta), ENC_W));
    assign o_hall_mag = HALL_W'(abs_sat(32'(w_hall_delta), HALL_W));

    assign o_bad = (o_enc_mag < ENC_MIN_V) && (o_hall_mag > HALL_MAX_V);

endmodule

// File: rtl/bldc_encoder_check_sequencer.sv
// Windowed encoder-plausibility sequencer with a latched strike-limit fault.
// Optional macro BLDC_ENC_CHECK_DECAY_EN: good windows decrement strikes instead of clearing.
module bldc_encoder_check_sequencer
    import bldc_pkg::*;
#(
    parameter int ENCODER_COUNTER_WIDTH = BLDC_ENC_W,
    parameter int HALL_COUNTER_WIDTH    = BLDC_HALL_W,
    parameter int ENC_MIN               = BLDC_ENC_MIN,
    parameter int HALL_MAX              = BLDC_HALL_MAX,
    parameter int STRIKE_LIMIT          = BLDC_STRIKE_LIMIT,
    parameter int STRIKE_WIDTH          = BLDC_STRIKE_W
) (
    input logic clk,
    input logic reset,
    bldc_encoder_check_sequencer_if.slave bus
);

    localparam int EW = ENCODER_COUNTER_WIDTH;
    localparam int HW = HALL_COUNTER_WIDTH;
    localparam int SW = STRIKE_WIDTH;

    localparam logic [SW-1:0] STRIKE_MAX = '1;
    localparam logic [SW-1:0] LIMIT_V    = SW'(STRIKE_LIMIT);
    localparam logic [SW-1:0] ONE_V      = SW'(1);

    state_e        r_state,     w_state_nxt;
    logic [EW-1:0] r_enc_base,  w_enc_base_nxt;
    logic [HW-1:0] r_hall_base, w_hall_base_nxt;
    logic          r_win_valid, w_win_valid_nxt;
    logic [EW-1:0] r_win_enc,   w_win_enc_nxt;
    logic [HW-1:0] r_win_hall,  w_win_hall_nxt;
    logic          r_win_bad,   w_win_bad_nxt;
    logic [SW-1:0] r_strikes,   w_strikes_nxt;
    logic          r_fault,     w_fault_nxt;

    logic [EW-1:0] w_enc_mag;
    logic [HW-1:0] w_hall_mag;
    logic          w_bad;
    logic [SW-1:0] w_strikes_judged;

    bldc_window_judge #(
        .ENC_W    (EW),
        .HALL_W   (HW),
        .ENC_MIN  (ENC_MIN),
        .HALL_MAX (HALL_MAX)
    ) u_judge (
        .i_enc_count  (bus.enc_count),
        .i_enc_base   (r_enc_base),
        .i_hall_count (bus.hall_count),
        .i_hall_base  (r_hall_base),
        .o_enc_mag    (w_enc_mag),
        .o_hall_mag   (w_hall_mag),
        .o_bad        (w_bad)
    );

    always_comb begin
        if (w_bad) begin
            w_strikes_judged = (r_strikes == STRIKE_MAX) ? r_strikes : r_strikes + ONE_V;
        end else begin
`ifdef BLDC_ENC_CHECK_DECAY_EN
            w_strikes_judged = (r_strikes == '0) ? '0 : r_strikes - ONE_V;
`else
            w_strikes_judged = '0;
`endif
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_state_nxt     = r_state;
        w_enc_base_nxt  = r_enc_base;
        w_hall_base_nxt = r_hall_base;
        w_win_valid_nxt = 1'b0;
        w_win_enc_nxt   = r_win_enc;
        w_win_hall_nxt  = r_win_hall;
        w_win_bad_nxt   = r_win_bad;
        w_strikes_nxt   = r_strikes;
        w_fault_nxt     = r_fault;

        case (r_state)
            ST_IDLE: begin
                w_strikes_nxt = '0;
                if (bus.enable) begin
                    w_state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!bus.enable) begin
                    w_state_nxt   = ST_IDLE;
                    w_strikes_nxt = '0;
                end else if (bus.fault_clear) begin
                    w_strikes_nxt = '0;
                end else if (bus.tick) begin
                    w_enc_base_nxt  = bus.enc_count;
                    w_hall_base_nxt = bus.hall_count;
                    w_state_nxt     = ST_RUN;
                end
            end
            ST_RUN: begin
                // Disable and clear both outrank a coincident tick.
                if (!bus.enable) begin
                    w_state_nxt   = ST_IDLE;
                    w_strikes_nxt = '0;
                end else if (bus.fault_clear) begin
                    w_strikes_nxt = '0;
                end else if (bus.tick) begin
                    w_enc_base_nxt  = bus.enc_count;
                    w_hall_base_nxt = bus.hall_count;
                    w_win_valid_nxt = 1'b1;
                    w_win_enc_nxt   = w_enc_mag;
                    w_win_hall_nxt  = w_hall_mag;
                    w_win_bad_nxt   = w_bad;
                    w_strikes_nxt   = w_strikes_judged;
                    if (w_strikes_judged >= LIMIT_V) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                if (bus.fault_clear) begin
                    w_fault_nxt   = 1'b0;
                    w_strikes_nxt = '0;
                    w_state_nxt   = bus.enable ? ST_ARM : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: the baselines are plain registers, so they take the async reset
    // along with the rest of the state; nothing here is a RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_enc_base  <= '0;
            r_hall_base <= '0;
            r_win_valid <= 1'b0;
            r_win_enc   <= '0;
            r_win_hall  <= '0;
            r_win_bad   <= 1'b0;
            r_strikes   <= '0;
            r_fault     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            r_state     <= w_state_nxt;
            r_enc_base  <= w_enc_base_nxt;
            r_hall_base <= w_hall_base_nxt;
            r_win_valid <= w_win_valid_nxt;
            r_win_enc   <= w_win_enc_nxt;
            r_win_hall  <= w_win_hall_nxt;
            r_win_bad   <= w_win_bad_nxt;
            r_strikes   <= w_strikes_nxt;
            r_fault     <= w_fault_nxt;
        end
    end

    assign bus.win_valid    = r_win_valid;
    assign bus.win_enc      = r_win_enc;
    assign bus.win_hall     = r_win_hall;
    assign bus.win_bad      = r_win_bad;
    assign bus.strike_count = r_strikes;
    assign bus.fault        = r_fault;

    // The fault flag and the FAULT state always travel together, and only
    // FAULT may hold a strike count at or above the limit.
    a_fault_state : assert property (@(posedge clk) disable iff (!reset)
        r_fault == (r_state == ST_FAULT));
    a_strike_bound : assert property (@(posedge clk) disable iff (!reset)
        (r_state != ST_FAULT) |-> (r_strikes < LIMIT_V));

endmodule

// File: tb/tb_bldc_encoder_check_sequencer.sv
// Self-checking bench: vector table, hand-written corner sequences and a
// randomized run against a behavioural window model.
module tb_bldc_encoder_check_sequencer;

    localparam int EW = 15;
    localparam int HW = 8;
    localparam int SW = 4;
    localparam int ENC_MIN = 2;
    localparam int HALL_MAX = 1;
    localparam int LIMIT = 3;
    localparam int SMAX = 15;
`ifdef BLDC_ENC_CHECK_DECAY_EN
    localparam bit DECAY = 1'b1;
`else
    localparam bit DECAY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;

    bldc_encoder_check_sequencer_if #(.ENC_W(EW), .HALL_W(HW), .STRIKE_W(SW)) bus ();

    bldc_encoder_check_sequencer #(
        .ENCODER_COUNTER_WIDTH (EW),
        .HALL_COUNTER_WIDTH    (HW),
        .ENC_MIN               (ENC_MIN),
        .HALL_MAX              (HALL_MAX),
        .STRIKE_LIMIT          (LIMIT),
        .STRIKE_WIDTH          (SW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en, tk, fc;
        logic [EW-1:0] enc;
        logic [HW-1:0] hall;
        logic          v;
        logic [EW-1:0] e_enc;
        logic [HW-1:0] e_hall;
        logic          bad;
        logic [SW-1:0] s;
        logic          f;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, tk, fc, input int enc, hall,
                                input logic v, input int e_enc, e_hall,
                                input logic bad, input int s, input logic f);
        vec_t r;
        r.en = en; r.tk = tk; r.fc = fc;
        r.enc = EW'(enc); r.hall = HW'(hall);
        r.v = v; r.e_enc = EW'(e_enc); r.e_hall = HW'(e_hall);
        r.bad = bad; r.s = SW'(s); r.f = f;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic v, input int e_enc, input int e_hall,
                              input logic bad, input int s, input logic f);
        check({tag, ".win_valid"},    32'(bus.win_valid),    32'(v));
        check({tag, ".win_enc"},      32'(bus.win_enc),      32'(e_enc));
        check({tag, ".win_hall"},     32'(bus.win_hall),     32'(e_hall));
        check({tag, ".win_bad"},      32'(bus.win_bad),      32'(bad));
        check({tag, ".strike_count"}, 32'(bus.strike_count), 32'(s));
        check({tag, ".fault"},        32'(bus.fault),        32'(f));
    endtask

    task automatic drive(input logic en, tk, fc, input int enc, hall);
        bus.enable      = en;
        bus.tick        = tk;
        bus.fault_clear = fc;
        bus.enc_count   = EW'(enc);
        bus.hall_count  = HW'(hall);
    endtask

    // Apply inputs at a falling edge and return at the next falling edge.
    task automatic cyc(input logic en, tk, fc, input int enc, hall);
        drive(en, tk, fc, enc, hall);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Behavioural model: windows judged by arithmetic on integer counts.
    localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_FAULT = 3;
    int m_mode, m_enc_base, m_hall_base, m_s, m_enc, m_hall;
    bit m_v, m_bad, m_f;

    function automatic int mag(input int diff, input int w);
        int full, half, m;
        full = 1 << w;
        half = 1 << (w - 1);
        m = diff % full;
        if (m < 0) m += full;
        if (m > half) m = full - m;
        else if (m == half) m = half - 1;
        return m;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_enc_base = 0; m_hall_base = 0; m_s = 0;
        m_enc = 0; m_hall = 0; m_v = 0; m_bad = 0; m_f = 0;
    endtask

    task automatic model_step(input bit en, tk, fc, input int enc, hall);
        int de, dh;
        m_v = 1'b0;
        if (m_mode == M_FAULT) begin
            if (fc) begin
                m_f = 1'b0; m_s = 0;
                m_mode = en ? M_ARM : M_IDLE;
            end
        end else if (m_mode == M_IDLE) begin
            m_s = 0;
            if (en) m_mode = M_ARM;
        end else if (!en) begin
            m_mode = M_IDLE; m_s = 0;
        end else if (fc) begin
            m_s = 0;
        end else if (tk && m_mode == M_ARM) begin
            m_enc_base = enc; m_hall_base = hall; m_mode = M_RUN;
        end else if (tk) begin
            de = mag(enc - m_enc_base, EW);
            dh = mag(hall - m_hall_base, HW);
            m_enc_base = enc; m_hall_base = hall;
            m_v = 1'b1; m_enc = de; m_hall = dh;
            m_bad = (de < ENC_MIN) && (dh > HALL_MAX);
            if (m_bad) m_s = (m_s < SMAX) ? m_s + 1 : SMAX;
            else m_s = DECAY ? ((m_s > 0) ? m_s - 1 : 0) : 0;
            if (m_s >= LIMIT) begin
                m_f = 1'b1; m_mode = M_FAULT;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int enc_cur, hall_cur;
        bit en, tk, fc;

        vecs.push_back(mk(1,0,0, 0,      0,   0, 0,      0,   0, 0, 0));
        vecs.push_back(mk(1,1,0, 10,     5,   0, 0,      0,   0, 0, 0));
        vecs.push_back(mk(1,1,0, 10,     8,   1, 0,      3,   1, 1, 0));
        vecs.push_back(mk(1,1,0, 10,     11,  1, 0,      3,   1, 2, 0));
        vecs.push_back(mk(1,1,0, 10,     14,  1, 0,      3,   1, 3, 1));
        vecs.push_back(mk(1,1,0, 10,     17,  0, 0,      3,   1, 3, 1));
        vecs.push_back(mk(1,0,0, 10,     17,  0, 0,      3,   1, 3, 1));
        vecs.push_back(mk(1,0,1, 10,     17,  0, 0,      3,   1, 0, 0));
        vecs.push_back(mk(1,1,0, 'h7FFE, 20,  0, 0,      3,   1, 0, 0));
        vecs.push_back(mk(1,1,0, 'h0003, 22,  1, 5,      2,   0, 0, 0));
        vecs.push_back(mk(1,1,0, 'h7F9F, 18,  1, 100,    4,   0, 0, 0));
        vecs.push_back(mk(1,1,0, 'h7F3B, 14,  1, 100,    4,   0, 0, 0));
        vecs.push_back(mk(1,1,0, 'h3F3B, 14,  1, 'h3FFF, 0,   0, 0, 0));
        vecs.push_back(mk(1,1,0, 'h3F3B, 142, 1, 0,      127, 1, 1, 0));
        vecs.push_back(mk(1,1,0, 'h3F3D, 144, 1, 2,      2,   0, 0, 0));
        vecs.push_back(mk(1,1,0, 'h3F3E, 145, 1, 1,      1,   0, 0, 0));
        vecs.push_back(mk(1,1,0, 'h3F3D, 143, 1, 1,      2,   1, 1, 0));
        vecs.push_back(mk(1,1,0, 'h3F3D, 146, 1, 0,      3,   1, 2, 0));
        vecs.push_back(mk(1,1,0, 'h3F47, 146, 1, 10,     0,   0, DECAY ? 1 : 0, 0));
        vecs.push_back(mk(1,1,0, 'h3F47, 148, 1, 0,      2,   1, DECAY ? 2 : 1, 0));
        vecs.push_back(mk(0,1,0, 'h3F47, 153, 0, 0,      2,   1, 0, 0));
        vecs.push_back(mk(1,0,0, 'h3F47, 153, 0, 0,      2,   1, 0, 0));
        vecs.push_back(mk(1,1,0, 100,    0,   0, 0,      2,   1, 0, 0));
        vecs.push_back(mk(1,1,0, 100,    0,   1, 0,      0,   0, 0, 0));

        drive(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        check_outs("in_reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        check_outs("after_reset", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].en, vecs[i].tk, vecs[i].fc, int'(vecs[i].enc), int'(vecs[i].hall));
            check_outs($sformatf("vec%0d", i), vecs[i].v, int'(vecs[i].e_enc),
                       int'(vecs[i].e_hall), vecs[i].bad, int'(vecs[i].s), vecs[i].f);
        end

        // Clear coincident with a bad tick at strike 2.
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 3);
        cyc(1, 1, 0, 0, 6);
        check("clr_tick.pre_strikes", 32'(bus.strike_count), 32'd2);
        cyc(1, 1, 1, 0, 9);
        check("clr_tick.valid", 32'(bus.win_valid), 32'd0);
        check("clr_tick.strikes", 32'(bus.strike_count), 32'd0);
        check("clr_tick.fault", 32'(bus.fault), 32'd0);
        cyc(1, 1, 0, 0, 12);
        check("clr_tick.next_valid", 32'(bus.win_valid), 32'd1);
        check("clr_tick.next_strikes", 32'(bus.strike_count), 32'd1);

        // Fault survives disable; clear while disabled returns to idle.
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 3);
        cyc(1, 1, 0, 0, 6);
        cyc(1, 1, 0, 0, 9);
        check("flt.fault", 32'(bus.fault), 32'd1);
        check("flt.strikes", 32'(bus.strike_count), 32'd3);
        cyc(0, 0, 0, 0, 9);
        check("flt.hold_disabled", 32'(bus.fault), 32'd1);
        cyc(0, 0, 1, 0, 9);
        check("flt.cleared", 32'(bus.fault), 32'd0);
        check("flt.cleared_strikes", 32'(bus.strike_count), 32'd0);
        cyc(0, 1, 0, 0, 12);
        check("flt.idle_tick", 32'(bus.win_valid), 32'd0);
        cyc(1, 0, 0, 0, 12);
        cyc(1, 1, 0, 0, 12);
        check("flt.arm_tick", 32'(bus.win_valid), 32'd0);
        cyc(1, 1, 0, 0, 15);
        check("flt.first_window", 32'(bus.win_valid), 32'd1);
        check("flt.first_bad", 32'(bus.win_bad), 32'd1);

        // Asynchronous reset in the middle of a run.
        drive(1, 1, 0, 0, 18);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_outs("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // Randomized run against the model.
        do_reset();
        model_reset();
        enc_cur = 0;
        hall_cur = 0;
        for (int n = 0; n < 600; n++) begin
            en = ($urandom_range(0, 39) != 0);
            tk = ($urandom_range(0, 1) != 0);
            fc = ($urandom_range(0, 19) == 0);
            if (tk) begin
                enc_cur += ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 65535))
                                                       : int'($urandom_range(0, 4)) - 2;
                hall_cur += int'($urandom_range(0, 8)) - 4;
            end
            cyc(en, tk, fc, enc_cur, hall_cur);
            model_step(en, tk, fc, int'(bus.enc_count), int'(bus.hall_count));
            check_outs($sformatf("rnd%0d", n), m_v, m_enc, m_hall, m_bad, m_s, m_f);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
